// File: rtl/alu_arbiter_if.sv
// Requester, response and flag signals shared between the two ALU clients,
// the response consumer and the alu_arbiter.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             in_Req0_Valid;
    logic [WIDTH-1:0] in_Req0_Rn;
    logic [WIDTH-1:0] in_Req0_Op2;
    logic [3:0]       in_Req0_Opcode;
    logic             in_Req0_SetFlags;
    logic             out_Req0_Ready;

    logic             in_Req1_Valid;
    logic [WIDTH-1:0] in_Req1_Rn;
    logic [WIDTH-1:0] in_Req1_Op2;
    logic [3:0]       in_Req1_Opcode;
    logic             in_Req1_SetFlags;
    logic             out_Req1_Ready;

    logic             out_Resp_Valid;
    logic             out_Resp_Id;
    logic [WIDTH-1:0] out_Resp_Y;
    logic [3:0]       out_Resp_CNZV;
    logic             in_Resp_Ready;

    logic [3:0]       out_Flags_CNZV;

    // Requesters and the response consumer
    modport master (
        output in_Req0_Valid, in_Req0_Rn, in_Req0_Op2, in_Req0_Opcode, in_Req0_SetFlags,
        output in_Req1_Valid, in_Req1_Rn, in_Req1_Op2, in_Req1_Opcode, in_Req1_SetFlags,
        output in_Resp_Ready,
        input  out_Req0_Ready, out_Req1_Ready,
        input  out_Resp_Valid, out_Resp_Id, out_Resp_Y, out_Resp_CNZV,
        input  out_Flags_CNZV
    );

    // The arbiter
    modport slave (
        input  in_Req0_Valid, in_Req0_Rn, in_Req0_Op2, in_Req0_Opcode, in_Req0_SetFlags,
        input  in_Req1_Valid, in_Req1_Rn, in_Req1_Op2, in_Req1_Opcode, in_Req1_SetFlags,
        input  in_Resp_Ready,
        output out_Req0_Ready, out_Req1_Ready,
        output out_Resp_Valid, out_Resp_Id, out_Resp_Y, out_Resp_CNZV,
        output out_Flags_CNZV
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between the
// execute stage (port 0) and the address/branch-target unit (port 1), with a
// one-entry response buffer and the architectural CNZV flag register.
// The alu module (ARM-style data-processing opcodes) lives in this file too.
`ifndef WordWidth
`define WordWidth 32
`endif

`ifndef ALUType_And
`define ALUType_And 4'd0
`define ALUType_Eor 4'd1
`define ALUType_Sub 4'd2
`define ALUType_Rsb 4'd3
`define ALUType_Add 4'd4
`define ALUType_Adc 4'd5
`define ALUType_Sbc 4'd6
`define ALUType_Rsc 4'd7
`define ALUType_Tst 4'd8
`define ALUType_Teq 4'd9
`define ALUType_Cmp 4'd10
`define ALUType_Cmn 4'd11
`define ALUType_Orr 4'd12
`define ALUType_Mov 4'd13
`define ALUType_Bic 4'd14
`define ALUType_Mvn 4'd15
`endif

module alu_arbiter #(
    parameter int WIDTH = `WordWidth
) (
    input logic         in_Clock,
    input logic         in_Reset,
    alu_arbiter_if.slave bus
);
    typedef enum logic {EMPTY, FULL} resp_state_t;

    resp_state_t      state;
    logic             last_grant;
    logic             resp_id;
    logic [WIDTH-1:0] resp_y;
    logic [3:0]       resp_cnzv;
    logic [3:0]       flags;

    logic             grant;
    logic             can_accept;
    logic             ready0;
    logic             ready1;
    logic             accept;
    logic             set_flags;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_y;
    logic [3:0]       alu_cnzv;

    // Grant: a lone requester wins; under contention the port not granted last wins
    always_comb begin
        grant = 1'b0;
        if (bus.in_Req0_Valid && bus.in_Req1_Valid) begin
            grant = ~last_grant;
        end else if (bus.in_Req1_Valid) begin
            grant = 1'b1;
        end
    end

    assign can_accept = (state == EMPTY) || bus.in_Resp_Ready;
    assign ready0     = !in_Reset && can_accept && bus.in_Req0_Valid && (grant == 1'b0);
    assign ready1     = !in_Reset && can_accept && bus.in_Req1_Valid && (grant == 1'b1);
    assign accept     = ready0 || ready1;

    // Operand mux feeding the shared ALU, steered by the grant
    always_comb begin
        alu_a     = bus.in_Req0_Rn;
        alu_b     = bus.in_Req0_Op2;
        alu_op    = bus.in_Req0_Opcode;
        set_flags = bus.in_Req0_SetFlags;
        if (grant) begin
            alu_a     = bus.in_Req1_Rn;
            alu_b     = bus.in_Req1_Op2;
            alu_op    = bus.in_Req1_Opcode;
            set_flags = bus.in_Req1_SetFlags;
        end
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .in_Opcode (alu_op),
        .in_A      (alu_a),
        .in_B      (alu_b),
        .in_Carry  (flags[3]),
        .out_Y     (alu_y),
        .out_CNZV  (alu_cnzv)
    );

    // Response buffer FSM, round-robin pointer and architectural flag register
    always_ff @(posedge in_Clock) begin
        if (in_Reset) begin
            state      <= EMPTY;
            resp_id    <= 1'b0;
            resp_y     <= '0;
            resp_cnzv  <= '0;
            flags      <= '0;
            last_grant <= 1'b1;
        end else begin
            if (accept) begin
                state      <= FULL;
                resp_id    <= grant;
                resp_y     <= alu_y;
                resp_cnzv  <= alu_cnzv;
                last_grant <= grant;
                if (set_flags) begin
                    flags <= alu_cnzv;
                end
            end else if ((state == FULL) && bus.in_Resp_Ready) begin
                state <= EMPTY;
            end
        end
    end

    assign bus.out_Req0_Ready = ready0;
    assign bus.out_Req1_Ready = ready1;
    assign bus.out_Resp_Valid = (state == FULL);
    assign bus.out_Resp_Id    = resp_id;
    assign bus.out_Resp_Y     = resp_y;
    assign bus.out_Resp_CNZV  = resp_cnzv;
    assign bus.out_Flags_CNZV = flags;
endmodule

// Combinational ALU. CNZV is packed as {C, N, Z, V}. Subtraction carry is the
// inverted borrow. Logical ops pass C through and clear V.
module alu #(
    parameter int WIDTH = `WordWidth
) (
    input  logic [3:0]       in_Opcode,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic             in_Carry,
    output logic [WIDTH-1:0] out_Y,
    output logic [3:0]       out_CNZV
);
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic             arith;
    logic [WIDTH-1:0] logic_y;
    logic [WIDTH:0]   sum;
    logic             c;
    logic             v;

    // Opcode decode into adder operands or a logical result
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        arith   = 1'b0;
        logic_y = '0;
        case (in_Opcode)
            `ALUType_And, `ALUType_Tst: logic_y = in_A & in_B;
            `ALUType_Eor, `ALUType_Teq: logic_y = in_A ^ in_B;
            `ALUType_Orr:               logic_y = in_A | in_B;
            `ALUType_Mov:               logic_y = in_B;
            `ALUType_Bic:               logic_y = in_A & ~in_B;
            `ALUType_Mvn:               logic_y = ~in_B;
            `ALUType_Sub, `ALUType_Cmp: begin
                arith = 1'b1; add_a = in_A; add_b = ~in_B; add_cin = 1'b1;
            end
            `ALUType_Rsb: begin
                arith = 1'b1; add_a = in_B; add_b = ~in_A; add_cin = 1'b1;
            end
            `ALUType_Add, `ALUType_Cmn: begin
                arith = 1'b1; add_a = in_A; add_b = in_B; add_cin = 1'b0;
            end
            `ALUType_Adc: begin
                arith = 1'b1; add_a = in_A; add_b = in_B; add_cin = in_Carry;
            end
            `ALUType_Sbc: begin
                arith = 1'b1; add_a = in_A; add_b = ~in_B; add_cin = in_Carry;
            end
            `ALUType_Rsc: begin
                arith = 1'b1; add_a = in_B; add_b = ~in_A; add_cin = in_Carry;
            end
            default: logic_y = '0;
        endcase
    end

    assign sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    // Result select and flag generation
    always_comb begin
        out_Y = arith ? sum[WIDTH-1:0] : logic_y;
        c     = arith ? sum[WIDTH] : in_Carry;
        v     = arith && (add_a[WIDTH-1] == add_b[WIDTH-1]) && (out_Y[WIDTH-1] != add_a[WIDTH-1]);
        out_CNZV = {c, out_Y[WIDTH-1], (out_Y == '0), v};
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, single op, contention, carry chain,
// flag isolation, backpressure and reset while the response buffer is full.
module tb_alu_arbiter;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_ADC = 4'd5;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    alu_arbiter_if #(.WIDTH(32)) bus ();

    alu_arbiter #(.WIDTH(32)) dut (
        .in_Clock (clk),
        .in_Reset (rst),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req0(input logic v, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic s);
        bus.in_Req0_Valid    = v;
        bus.in_Req0_Opcode   = op;
        bus.in_Req0_Rn       = a;
        bus.in_Req0_Op2      = b;
        bus.in_Req0_SetFlags = s;
    endtask

    task automatic req1(input logic v, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic s);
        bus.in_Req1_Valid    = v;
        bus.in_Req1_Opcode   = op;
        bus.in_Req1_Rn       = a;
        bus.in_Req1_Op2      = b;
        bus.in_Req1_SetFlags = s;
    endtask

    task automatic check_resp(input string tag, input logic id, input logic [31:0] y,
                              input logic [3:0] cnzv, input logic [3:0] flg);
        check({tag, "_valid"}, {31'd0, bus.out_Resp_Valid}, 32'd1);
        check({tag, "_id"},    {31'd0, bus.out_Resp_Id}, {31'd0, id});
        check({tag, "_y"},     bus.out_Resp_Y, y);
        check({tag, "_cnzv"},  {28'd0, bus.out_Resp_CNZV}, {28'd0, cnzv});
        check({tag, "_flags"}, {28'd0, bus.out_Flags_CNZV}, {28'd0, flg});
    endtask

    task automatic check_ready(input string tag, input logic r0, input logic r1);
        check({tag, "_ready0"}, {31'd0, bus.out_Req0_Ready}, {31'd0, r0});
        check({tag, "_ready1"}, {31'd0, bus.out_Req1_Ready}, {31'd0, r1});
    endtask

    initial begin
        tests = 0;
        fails = 0;

        // Reset with both ports valid
        rst = 1'b1;
        bus.in_Resp_Ready = 1'b1;
        req0(1'b1, OP_ADD, 32'd2, 32'd3, 1'b0);
        req1(1'b1, OP_ADD, 32'd10, 32'd20, 1'b0);
        tick();
        tick();
        check("rst_valid", {31'd0, bus.out_Resp_Valid}, 32'd0);
        check("rst_id",    {31'd0, bus.out_Resp_Id}, 32'd0);
        check("rst_y",     bus.out_Resp_Y, 32'd0);
        check("rst_cnzv",  {28'd0, bus.out_Resp_CNZV}, 32'd0);
        check("rst_flags", {28'd0, bus.out_Flags_CNZV}, 32'd0);
        check_ready("rst", 1'b0, 1'b0);

        // Contention: first accept after reset goes to port 0, then alternates
        rst = 1'b0;
        #1;
        check_ready("cont0", 1'b1, 1'b0);
        tick();
        check_resp("cont0", 1'b0, 32'd5, 4'b0000, 4'b0000);
        #1;
        check_ready("cont1", 1'b0, 1'b1);
        tick();
        check_resp("cont1", 1'b1, 32'd30, 4'b0000, 4'b0000);
        #1;
        check_ready("cont2", 1'b1, 1'b0);
        tick();
        check_resp("cont2", 1'b0, 32'd5, 4'b0000, 4'b0000);
        #1;
        check_ready("cont3", 1'b0, 1'b1);
        tick();
        check_resp("cont3", 1'b1, 32'd30, 4'b0000, 4'b0000);

        // Carry chain on port 1: ADD sets C and Z, following ADC consumes C
        req0(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0);
        req1(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1);
        #1;
        check_ready("carry_add", 1'b0, 1'b1);
        tick();
        check_resp("carry_add", 1'b1, 32'd0, 4'b1010, 4'b1010);
        req1(1'b1, OP_ADC, 32'd1, 32'd1, 1'b1);
        tick();
        check_resp("carry_adc", 1'b1, 32'd3, 4'b0000, 4'b0000);

        // Carry produced without SetFlags leaves the flag register alone
        req1(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0);
        req0(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0);
        tick();
        check_resp("nos_add", 1'b0, 32'd0, 4'b1010, 4'b0000);

        // Signed overflow without SetFlags
        req0(1'b1, OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0);
        tick();
        check_resp("ovf_add", 1'b0, 32'h8000_0000, 4'b0101, 4'b0000);

        // Borrowing subtract gives negative, C clear
        req0(1'b1, OP_SUB, 32'd2, 32'd9, 1'b0);
        tick();
        check_resp("neg_sub", 1'b0, 32'hFFFF_FFF9, 4'b0100, 4'b0000);

        // Backpressure: Y=5 buffered, consumer stalls, port 0 waits
        req0(1'b1, OP_ADD, 32'd2, 32'd3, 1'b0);
        tick();
        check_resp("bp_load", 1'b0, 32'd5, 4'b0000, 4'b0000);
        bus.in_Resp_Ready = 1'b0;
        req0(1'b1, OP_SUB, 32'd9, 32'd2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_ready0", {31'd0, bus.out_Req0_Ready}, 32'd0);
            tick();
            check_resp("bp_hold", 1'b0, 32'd5, 4'b0000, 4'b0000);
        end
        bus.in_Resp_Ready = 1'b1;
        #1;
        check("bp_release_ready0", {31'd0, bus.out_Req0_Ready}, 32'd1);
        tick();
        check_resp("bp_sub", 1'b0, 32'd7, 4'b1000, 4'b1000);

        // Reset while FULL discards the response, clears flags and pointer
        req0(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0);
        bus.in_Resp_Ready = 1'b0;
        tick();
        check_resp("pre_rst", 1'b0, 32'd7, 4'b1000, 4'b1000);
        rst = 1'b1;
        tick();
        check("full_rst_valid", {31'd0, bus.out_Resp_Valid}, 32'd0);
        check("full_rst_flags", {28'd0, bus.out_Flags_CNZV}, 32'd0);
        check("full_rst_y",     bus.out_Resp_Y, 32'd0);
        rst = 1'b0;
        bus.in_Resp_Ready = 1'b1;
        req0(1'b1, OP_ADD, 32'd2, 32'd3, 1'b0);
        req1(1'b1, OP_ADD, 32'd10, 32'd20, 1'b0);
        #1;
        check_ready("post_rst", 1'b1, 1'b0);
        tick();
        check_resp("post_rst", 1'b0, 32'd5, 4'b0000, 4'b0000);

        // Consumer drains the last response with no new request
        req0(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0);
        req1(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0);
        tick();
        check("drain_valid", {31'd0, bus.out_Resp_Valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
